// File: rtl/greedy_snake_pkg.sv
// -----------------------------------------------------------------------------
// greedy_snake_pkg
// Shared definitions for the GreedySnake HDMI raster timing generator.
//   CNT_W          : width of every timing input and coordinate output
//   state_t        : generator state encoding (IDLE, RUN)
//   SVGA_*         : 800x600@60 timing set (1056/128/88/800, 628/4/23/600)
// -----------------------------------------------------------------------------
package greedy_snake_pkg;

  localparam int CNT_W = 12;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] SVGA_H_TOTAL  = 12'd1056;
  localparam logic [CNT_W-1:0] SVGA_H_SYNC   = 12'd128;
  localparam logic [CNT_W-1:0] SVGA_H_BPORCH = 12'd88;
  localparam logic [CNT_W-1:0] SVGA_H_RES    = 12'd800;
  localparam logic [CNT_W-1:0] SVGA_V_TOTAL  = 12'd628;
  localparam logic [CNT_W-1:0] SVGA_V_SYNC   = 12'd4;
  localparam logic [CNT_W-1:0] SVGA_V_BPORCH = 12'd23;
  localparam logic [CNT_W-1:0] SVGA_V_RES    = 12'd600;

endpackage

// File: rtl/greedy_snake_axis_cnt.sv
// -----------------------------------------------------------------------------
// greedy_snake_axis_cnt
// One axis (horizontal or vertical) of the raster timing generator: a raw
// position counter that wraps at total-1, plus the sync / active-window decode
// and the 1-based active coordinate for the current count.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   clear          : hold the counter at 0 (generator idle)
//   inc_en         : advance the counter this clock (tied high for H,
//                    driven by the H wrap for V)
//   total, sync_len, bporch, res : timing set for this axis
//   wrap           : counter is at its last position (total-1)
//   sync_raw       : counter is inside the sync pulse
//   act            : counter is inside the active window
//   pos            : 1-based position inside the active window (valid when act)
// -----------------------------------------------------------------------------
module greedy_snake_axis_cnt #(
  parameter int CNT_W = greedy_snake_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc_en,
  input  logic [CNT_W-1:0] total,
  input  logic [CNT_W-1:0] sync_len,
  input  logic [CNT_W-1:0] bporch,
  input  logic [CNT_W-1:0] res,
  output logic             wrap,
  output logic             sync_raw,
  output logic             act,
  output logic [CNT_W-1:0] pos
);

  import greedy_snake_pkg::*;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic [CNT_W:0]   act_start;
  logic [CNT_W:0]   act_stop;

  // Using >= rather than == keeps the counter from running away if an
  // out-of-range total is ever programmed (e.g. total=0 wraps at all-ones).
  assign last = total - CNT_W'(1);
  assign wrap = (cnt >= last);

  // Window bounds carry one extra bit so sync+bporch+res cannot alias.
  assign act_start = {1'b0, sync_len} + {1'b0, bporch};
  assign act_stop  = act_start + {1'b0, res};

  assign sync_raw = (cnt < sync_len);
  assign act      = ({1'b0, cnt} >= act_start) && ({1'b0, cnt} < act_stop);
  assign pos      = cnt - act_start[CNT_W-1:0] + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (inc_en) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/greedy_snake_hdmi_clk.sv
// -----------------------------------------------------------------------------
// greedy_snake_hdmi_clk
// Programmable raster video timing generator for the GreedySnake HDMI path.
// Generates whole frames while I_en is high; timing inputs are captured at
// start and at each frame boundary only, so a frame is never disturbed by
// register writes or by dropping I_en mid-frame.
// Ports:
//   I_pxl_clk            : pixel clock, rising edge
//   I_rst_n              : synchronous active-low reset
//   I_en                 : run request (sampled at idle and frame boundaries)
//   I_h_total/sync/bporch/res, I_v_total/sync/bporch/res : timing set
//   O_h_cnt, O_v_cnt     : 1-based active coordinates, 0 outside active area
//   O_busy               : frame in progress
//   O_de, O_hs, O_vs     : data enable and syncs, all registered and aligned
// Build option:
//   HDMI_SYNC_NEG_POL_EN : when defined, O_hs/O_vs are active-low (idle 1);
//                          otherwise active-high (idle 0).
// -----------------------------------------------------------------------------
module greedy_snake_hdmi_clk #(
  parameter int CNT_W = greedy_snake_pkg::CNT_W
) (
  input  logic             I_pxl_clk,
  input  logic             I_rst_n,
  input  logic             I_en,
  input  logic [CNT_W-1:0] I_h_total,
  input  logic [CNT_W-1:0] I_h_sync,
  input  logic [CNT_W-1:0] I_h_bporch,
  input  logic [CNT_W-1:0] I_h_res,
  input  logic [CNT_W-1:0] I_v_total,
  input  logic [CNT_W-1:0] I_v_sync,
  input  logic [CNT_W-1:0] I_v_bporch,
  input  logic [CNT_W-1:0] I_v_res,
  output logic [CNT_W-1:0] O_h_cnt,
  output logic [CNT_W-1:0] O_v_cnt,
  output logic             O_busy,
  output logic             O_de,
  output logic             O_hs,
  output logic             O_vs
);

  import greedy_snake_pkg::*;

`ifdef HDMI_SYNC_NEG_POL_EN
  localparam logic SYNC_ON = 1'b0;
`else
  localparam logic SYNC_ON = 1'b1;
`endif

  state_t state;
  state_t state_nxt;
  logic   load;

  logic [CNT_W-1:0] sh_h_total;
  logic [CNT_W-1:0] sh_h_sync;
  logic [CNT_W-1:0] sh_h_bporch;
  logic [CNT_W-1:0] sh_h_res;
  logic [CNT_W-1:0] sh_v_total;
  logic [CNT_W-1:0] sh_v_sync;
  logic [CNT_W-1:0] sh_v_bporch;
  logic [CNT_W-1:0] sh_v_res;

  logic             running;
  logic             h_wrap;
  logic             h_sync_raw;
  logic             h_act;
  logic [CNT_W-1:0] h_pos;
  logic             v_wrap;
  logic             v_sync_raw;
  logic             v_act;
  logic [CNT_W-1:0] v_pos;
  logic             frame_end;
  logic             de_raw;

  assign running   = (state == RUN);
  assign frame_end = h_wrap && v_wrap;

  greedy_snake_axis_cnt #(.CNT_W(CNT_W)) u_h_axis (
    .clk      (I_pxl_clk),
    .rst_n    (I_rst_n),
    .clear    (!running),
    .inc_en   (1'b1),
    .total    (sh_h_total),
    .sync_len (sh_h_sync),
    .bporch   (sh_h_bporch),
    .res      (sh_h_res),
    .wrap     (h_wrap),
    .sync_raw (h_sync_raw),
    .act      (h_act),
    .pos      (h_pos)
  );

  // The vertical counter steps once per line, on the horizontal wrap.
  greedy_snake_axis_cnt #(.CNT_W(CNT_W)) u_v_axis (
    .clk      (I_pxl_clk),
    .rst_n    (I_rst_n),
    .clear    (!running),
    .inc_en   (h_wrap),
    .total    (sh_v_total),
    .sync_len (sh_v_sync),
    .bporch   (sh_v_bporch),
    .res      (sh_v_res),
    .wrap     (v_wrap),
    .sync_raw (v_sync_raw),
    .act      (v_act),
    .pos      (v_pos)
  );

  // State register.
  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and shadow-load strobe. I_en only matters when idle or on the
  // last pixel of a frame, which is what keeps frames from being truncated.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (I_en) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (frame_end) begin
          if (I_en) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow timing registers; the decode only ever sees these.
  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst_n) begin
      sh_h_total  <= CNT_W'(SVGA_H_TOTAL);
      sh_h_sync   <= CNT_W'(SVGA_H_SYNC);
      sh_h_bporch <= CNT_W'(SVGA_H_BPORCH);
      sh_h_res    <= CNT_W'(SVGA_H_RES);
      sh_v_total  <= CNT_W'(SVGA_V_TOTAL);
      sh_v_sync   <= CNT_W'(SVGA_V_SYNC);
      sh_v_bporch <= CNT_W'(SVGA_V_BPORCH);
      sh_v_res    <= CNT_W'(SVGA_V_RES);
    end else if (load) begin
      sh_h_total  <= I_h_total;
      sh_h_sync   <= I_h_sync;
      sh_h_bporch <= I_h_bporch;
      sh_h_res    <= I_h_res;
      sh_v_total  <= I_v_total;
      sh_v_sync   <= I_v_sync;
      sh_v_bporch <= I_v_bporch;
      sh_v_res    <= I_v_res;
    end
  end

  assign de_raw = running && h_act && v_act;

  // Output stage: everything is registered from the same raw counters, so all
  // five video outputs and O_busy stay aligned one clock behind the counters.
  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst_n) begin
      O_busy  <= 1'b0;
      O_de    <= 1'b0;
      O_hs    <= ~SYNC_ON;
      O_vs    <= ~SYNC_ON;
      O_h_cnt <= '0;
      O_v_cnt <= '0;
    end else begin
      O_busy  <= running;
      O_de    <= de_raw;
      O_hs    <= (running && h_sync_raw) ? SYNC_ON : ~SYNC_ON;
      O_vs    <= (running && v_sync_raw) ? SYNC_ON : ~SYNC_ON;
      O_h_cnt <= de_raw ? h_pos : '0;
      O_v_cnt <= de_raw ? v_pos : '0;
    end
  end

endmodule

// File: tb/tb_greedy_snake_hdmi_clk.sv
// -----------------------------------------------------------------------------
// tb_greedy_snake_hdmi_clk
// Self-checking bench for greedy_snake_hdmi_clk. A behavioural frame model
// predicts the registered outputs for every clock; predictions are queued
// before the edge and compared after it. Window counters over DUT outputs are
// also compared against values worked out from the timing sets.
// Honours HDMI_SYNC_NEG_POL_EN for the expected sync polarity.
// -----------------------------------------------------------------------------
module tb_greedy_snake_hdmi_clk;

  localparam int CNT_W = 12;

`ifdef HDMI_SYNC_NEG_POL_EN
  localparam logic SYNC_ON = 1'b0;
`else
  localparam logic SYNC_ON = 1'b1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [CNT_W-1:0] h_total, h_sync, h_bporch, h_res;
  logic [CNT_W-1:0] v_total, v_sync, v_bporch, v_res;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             busy, de, hs, vs;

  greedy_snake_hdmi_clk #(.CNT_W(CNT_W)) dut (
    .I_pxl_clk  (clk),
    .I_rst_n    (rst_n),
    .I_en       (en),
    .I_h_total  (h_total),
    .I_h_sync   (h_sync),
    .I_h_bporch (h_bporch),
    .I_h_res    (h_res),
    .I_v_total  (v_total),
    .I_v_sync   (v_sync),
    .I_v_bporch (v_bporch),
    .I_v_res    (v_res),
    .O_h_cnt    (h_cnt),
    .O_v_cnt    (v_cnt),
    .O_busy     (busy),
    .O_de       (de),
    .O_hs       (hs),
    .O_vs       (vs)
  );

  always #5 clk = ~clk;

  // {busy, de, hs, vs, h_cnt, v_cnt}
  logic [27:0] sb_q[$];

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  // reference model state
  bit m_run = 0;
  int m_hc = 0, m_vc = 0;
  int s_ht, s_hs, s_hb, s_hr, s_vt, s_vs, s_vb, s_vr;

  // window statistics over DUT outputs
  int n_busy, n_de, n_hs, n_vs, n_end, n_busy_rise, max_h, max_v;
  int end_h, end_v;
  logic prev_busy = 1'b0;

  task automatic clear_stats();
    n_busy = 0; n_de = 0; n_hs = 0; n_vs = 0; n_end = 0;
    n_busy_rise = 0; max_h = 0; max_v = 0;
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Pop the oldest prediction and compare it with what the DUT now shows.
  task automatic checkOutput(input string tag);
    logic [27:0] exp_v, obs_v;
    exp_v = sb_q.pop_front();
    obs_v = {busy, de, hs, vs, h_cnt, v_cnt};
    checks++;
    assert (obs_v === exp_v)
    else begin
      errors++;
      $error("[TB] FAIL %s step %0d: observed busy/de/hs/vs/h/v=%b%b%b%b/%0d/%0d expected=%b%b%b%b/%0d/%0d",
             tag, step_no, obs_v[27], obs_v[26], obs_v[25], obs_v[24], obs_v[23:12], obs_v[11:0],
             exp_v[27], exp_v[26], exp_v[25], exp_v[24], exp_v[23:12], exp_v[11:0]);
    end
    if (busy === 1'b1) n_busy++;
    if (busy === 1'b1 && prev_busy !== 1'b1) n_busy_rise++;
    prev_busy = busy;
    if (de === 1'b1) n_de++;
    if (hs === SYNC_ON) n_hs++;
    if (vs === SYNC_ON) n_vs++;
    if (int'(h_cnt) == end_h && int'(v_cnt) == end_v && de === 1'b1) n_end++;
    if (int'(h_cnt) > max_h) max_h = int'(h_cnt);
    if (int'(v_cnt) > max_v) max_v = int'(v_cnt);
  endtask

  // One clock: predict from the model, queue it, clock the DUT, compare.
  task automatic applyStimulus(input string tag);
    logic [27:0] e;
    int hstart, vstart, col, row;
    e = {1'b0, 1'b0, ~SYNC_ON, ~SYNC_ON, 12'd0, 12'd0};
    if (!rst_n) begin
      m_run = 0; m_hc = 0; m_vc = 0;
    end else begin
      if (m_run) begin
        hstart = s_hs + s_hb;
        vstart = s_vs + s_vb;
        col = m_hc - hstart + 1;
        row = m_vc - vstart + 1;
        e[27] = 1'b1;
        e[25] = (m_hc < s_hs) ? SYNC_ON : ~SYNC_ON;
        e[24] = (m_vc < s_vs) ? SYNC_ON : ~SYNC_ON;
        if (col >= 1 && col <= s_hr && row >= 1 && row <= s_vr) begin
          e[26] = 1'b1;
          e[23:12] = 12'(col);
          e[11:0]  = 12'(row);
        end
        if (m_hc == s_ht - 1) begin
          m_hc = 0;
          if (m_vc == s_vt - 1) begin
            m_vc = 0;
            if (en) begin
              s_ht = h_total; s_hs = h_sync; s_hb = h_bporch; s_hr = h_res;
              s_vt = v_total; s_vs = v_sync; s_vb = v_bporch; s_vr = v_res;
            end else begin
              m_run = 0;
            end
          end else begin
            m_vc++;
          end
        end else begin
          m_hc++;
        end
      end else if (en) begin
        s_ht = h_total; s_hs = h_sync; s_hb = h_bporch; s_hr = h_res;
        s_vt = v_total; s_vs = v_sync; s_vb = v_bporch; s_vr = v_res;
        m_run = 1; m_hc = 0; m_vc = 0;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    checkOutput(tag);
  endtask

  task automatic set_small(input int hr);
    h_total = 12'd10; h_sync = 12'd2; h_bporch = 12'd2; h_res = 12'(hr);
    v_total = 12'd6;  v_sync = 12'd1; v_bporch = 12'd1; v_res = 12'd3;
  endtask

  int start_step;
  bit found;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    set_small(4);
    end_h = 4; end_v = 3;

    // reset, then idle with I_en low
    $display("[TB] reset and idle");
    for (int i = 0; i < 3; i++) applyStimulus("reset");
    rst_n = 1'b1;
    clear_stats();
    for (int i = 0; i < 100; i++) applyStimulus("idle");
    checkValue("idle_busy_cycles", n_busy, 0);
    checkValue("idle_de_cycles", n_de, 0);

    // single frame from a one-clock I_en pulse
    $display("[TB] single frame");
    clear_stats();
    en = 1'b1;
    applyStimulus("single");
    en = 1'b0;
    for (int i = 0; i < 69; i++) applyStimulus("single");
    checkValue("single_busy_cycles", n_busy, 60);
    checkValue("single_de_cycles", n_de, 12);
    checkValue("single_hs_cycles", n_hs, 12);
    checkValue("single_vs_cycles", n_vs, 10);
    checkValue("single_max_h", max_h, 4);
    checkValue("single_max_v", max_v, 3);
    checkValue("single_end_of_picture", n_end, 1);

    // three back-to-back frames
    $display("[TB] continuous frames");
    clear_stats();
    en = 1'b1;
    for (int i = 0; i < 151; i++) applyStimulus("cont");
    en = 1'b0;
    for (int i = 0; i < 49; i++) applyStimulus("cont");
    checkValue("cont_busy_cycles", n_busy, 180);
    checkValue("cont_busy_rises", n_busy_rise, 1);
    checkValue("cont_vs_cycles", n_vs, 30);
    checkValue("cont_de_cycles", n_de, 36);
    checkValue("cont_end_of_picture", n_end, 3);

    // h_res changed mid-frame takes effect on the following frame only
    $display("[TB] mid-frame h_res change");
    clear_stats();
    en = 1'b1;
    for (int i = 0; i < 31; i++) applyStimulus("hres_f1");
    h_res = 12'd3;
    for (int i = 0; i < 30; i++) applyStimulus("hres_f1");
    checkValue("hres_frame1_de", n_de, 12);
    checkValue("hres_frame1_max_h", max_h, 4);
    en = 1'b0;
    clear_stats();
    end_h = 3;
    for (int i = 0; i < 70; i++) applyStimulus("hres_f2");
    checkValue("hres_frame2_de", n_de, 9);
    checkValue("hres_frame2_max_h", max_h, 3);
    checkValue("hres_frame2_busy", n_busy, 60);
    checkValue("hres_frame2_end", n_end, 1);
    set_small(4);
    end_h = 4;

    // reset pulse during line 3
    $display("[TB] mid-frame reset");
    en = 1'b1;
    applyStimulus("rst_mid");
    en = 1'b0;
    for (int i = 0; i < 32; i++) applyStimulus("rst_mid");
    rst_n = 1'b0;
    applyStimulus("rst_mid");
    rst_n = 1'b1;
    clear_stats();
    for (int i = 0; i < 20; i++) applyStimulus("rst_after");
    checkValue("rst_after_busy", n_busy, 0);
    checkValue("rst_after_vs", n_vs, 0);
    clear_stats();
    en = 1'b1;
    applyStimulus("restart");
    en = 1'b0;
    for (int i = 0; i < 69; i++) applyStimulus("restart");
    checkValue("restart_busy", n_busy, 60);
    checkValue("restart_de", n_de, 12);

    // SVGA timing: first active pixel position and first active line
    $display("[TB] SVGA start of picture");
    h_total = 12'd1056; h_sync = 12'd128; h_bporch = 12'd88; h_res = 12'd800;
    v_total = 12'd628;  v_sync = 12'd4;   v_bporch = 12'd23; v_res = 12'd600;
    end_h = 800; end_v = 600;
    en = 1'b1;
    applyStimulus("svga");
    start_step = step_no;
    found = 1'b0;
    for (int i = 0; i < 30000 && !found; i++) begin
      applyStimulus("svga");
      if (de === 1'b1) found = 1'b1;
    end
    checkValue("svga_first_de_offset", step_no - start_step, 27 * 1056 + 216 + 1);
    checkValue("svga_first_h", int'(h_cnt), 1);
    checkValue("svga_first_v", int'(v_cnt), 1);
    clear_stats();
    for (int i = 0; i < 1000; i++) applyStimulus("svga_line");
    checkValue("svga_line_de", n_de, 799);
    checkValue("svga_line_hs", n_hs, 128);
    checkValue("svga_line_max_h", max_h, 800);
    checkValue("svga_line_busy", n_busy, 1000);
    checkValue("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
